sw_operand_entry: RTL and testbench
===================================

Name: sw_operand_entry

Overview:
- Input-side counterpart to the adder/seven-segment display path: reads the board switches and a push-button, and delivers registered operands A, B, Cin to Adder4.
- Instead of wiring SW straight to the adder, the user keys in operands in two steps:
  - set SW[3:0], press KEY to capture A;
  - set SW[3:0] and SW[8], press KEY to capture B and Cin.
- The block synchronises and debounces the raw board inputs, runs the entry state machine, pulses valid when a full operand set is ready, and exports the entry phase for LED or dp indication.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronised key level must hold before it is accepted (10 ms at 50 MHz); minimum 2.
- CNT_W, 19, debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- SW  input  10  raw slide switches: [3:0] operand nibble, [8] carry-in, [9] abort, [7:4] unused.
- key_n  input  1  raw push-button, active-low (0 = pressed).
- A  output  4  captured operand A, registered.
- B  output  4  captured operand B, registered.
- Cin  output  1  captured carry-in, registered.
- valid  output  1  one-cycle pulse when A, B and Cin form a new complete set.
- phase  output  2  entry state: 0 = GET_A, 1 = GET_B, 2 = SHOW; 3 is never driven.

Behaviour:
- Reset (synchronous, active-high):
  - A = 0, B = 0, Cin = 0, valid = 0, phase = 0 (GET_A).
  - Key synchroniser flops and the debounced key level = 1 (released).
  - SW synchroniser flops = 0; debounce counter = 0.
- Synchronisers:
  - key_n passes through two flops (r1, r2); SW[9:0] passes through two flops (sw_s).
  - All decisions use the synchronised values only.
- Debounce (per edge):
  - If r2 != stable: cnt <= cnt + 1.
  - If additionally cnt == DEBOUNCE_CYCLES-1: stable <= r2 and cnt <= 0.
  - If r2 == stable: cnt <= 0.
  - press = (stable == 1) && (r2 == 0) && (cnt == DEBOUNCE_CYCLES-1), evaluated combinationally and acted on at that same edge.
- Press timing:
  - key_n falls before edge k and is held low → stable falls and press acts at edge k+1+DEBOUNCE_CYCLES.
  - Any bounce shorter than DEBOUNCE_CYCLES restarts the count.
  - A held key produces exactly one press.
  - The release is debounced the same way and produces no event.
- FSM, on press:
  - GET_A: A <= sw_s[3:0]; go to GET_B.
  - GET_B: B <= sw_s[3:0], Cin <= sw_s[8]; valid = 1 in the following cycle only; go to SHOW.
  - SHOW: go to GET_A. A, B and Cin keep their values until overwritten by the next capture.
- Abort:
  - When sw_s[9] == 1: state <= GET_A, A <= 0, B <= 0, Cin <= 0, valid <= 0.
  - Abort is evaluated every cycle while high and has priority over press; presses during abort are discarded.
  - The debounce logic keeps running during abort.
- Simultaneous reset and abort/press: reset wins.
- A reset mid-debounce discards any partial count.
- Outputs change only on clk edges; there are no combinational paths from input to output.

Decomposition:
- Package sw_entry_pkg:
  - entry_state_t enum {GET_A = 2'd0, GET_B = 2'd1, SHOW = 2'd2}.
  - Constants SW_NIB_LSB = 0, SW_CIN = 8, SW_ABORT = 9.
- Sub-module key_debounce:
  - Contains the 2-flop synchroniser, the counter and the stable register.
  - Parameters DEBOUNCE_CYCLES, CNT_W; outputs stable and press.
  - Reusable for the other KEY inputs on the board.
- The top contains the SW synchroniser, the FSM and the output registers.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES = 4, CNT_W = 3.)
- Reset: assert reset for 2 cycles with arbitrary SW/key_n → A = 0, B = 0, Cin = 0, valid = 0, phase = 0 on the first edge after reset.
- Clean entry:
  - SW[3:0] = 4'h9; key_n low before edge 0 → A = 9 and phase = 1 after edge 5.
  - Release; SW[3:0] = 4'h7, SW[8] = 1; press again → B = 7, Cin = 1, phase = 2, then valid high for exactly 1 cycle.
- Bounce: key_n toggles 0,1,0,1 on consecutive cycles, then holds 0 → no capture until 4 consecutive synchronised-low cycles; exactly one A capture.
- Held key: key_n held low for 40 cycles in GET_A → one capture only, phase = 1 (not 2); no valid pulse.
- Abort:
  - In GET_B with A = 5, set SW[9] = 1 and press simultaneously → after the sync latency A = 0 and phase = 0; the press is ignored.
  - Clear SW[9] and press → A captured normally.
- Wrap: from SHOW (A = 3, B = 4) press → phase = 0, A and B still 3 and 4, valid = 0. Next press with SW[3:0] = 4'hF → A = 15, B still 4.

Source files
------------

// File: rtl/sw_entry_pkg.sv
// sw_entry_pkg: shared entry-state encoding and switch bit positions
package sw_entry_pkg;
  typedef enum logic [1:0] {GET_A = 2'd0, GET_B = 2'd1, SHOW = 2'd2} entry_state_t;
  localparam int SW_NIB_LSB = 0;
  localparam int SW_CIN = 8;
  localparam int SW_ABORT = 9;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus counter debounce for an active-low key, one press pulse per accepted fall
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic stable,
  output logic press
);
  logic r1, r2, done;
  logic [CNT_W-1:0] cnt;
  assign done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  assign press = stable && !r2 && done;
  always_ff @(posedge clk)
    if (reset) begin
      r1 <= 1'b1;
      r2 <= 1'b1;
      stable <= 1'b1;
      cnt <= '0;
    end else begin
      r1 <= key_n;
      r2 <= r1;
      cnt <= (r2 != stable && !done) ? cnt + 1'b1 : '0;
      if (r2 != stable && done) stable <= r2;
    end
endmodule

// File: rtl/sw_operand_entry.sv
// sw_operand_entry: two-step keyed entry of adder operands A, then B/Cin, from board switches
module sw_operand_entry
  import sw_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] SW,
  input  logic       key_n,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       Cin,
  output logic       valid,
  output logic [1:0] phase
);
  logic [9:0] sw_m, sw_s;
  logic press, key_level, abort, cap_a, cap_b;
  logic unused_ok;
  entry_state_t state, state_d;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .stable(key_level),
    .press(press)
  );
  always_ff @(posedge clk)
    if (reset) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= SW;
      sw_s <= sw_m;
    end
  assign abort = sw_s[SW_ABORT];
  assign unused_ok = ^{sw_s[7:4], key_level};
  always_ff @(posedge clk) state <= reset ? GET_A : state_d;
  always_comb
    state_d = abort ? GET_A
            : !press ? state
            : state == GET_A ? GET_B
            : state == GET_B ? SHOW
            : GET_A;
  always_comb begin
    cap_a = press && !abort && state == GET_A;
    cap_b = press && !abort && state == GET_B;
  end
  // abort clears operands every cycle it is held, overriding any capture
  always_ff @(posedge clk)
    if (reset || abort) begin
      A <= '0;
      B <= '0;
      Cin <= 1'b0;
      valid <= 1'b0;
    end else begin
      if (cap_a) A <= sw_s[SW_NIB_LSB +: 4];
      if (cap_b) B <= sw_s[SW_NIB_LSB +: 4];
      if (cap_b) Cin <= sw_s[SW_CIN];
      valid <= cap_b;
    end
  assign phase = state;
endmodule

// File: tb/tb_sw_operand_entry.sv
// tb_sw_operand_entry: scoreboard bench for keyed operand entry with a short debounce window
module tb_sw_operand_entry;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] SW = '0;
  logic key_n = 1'b1;
  logic [3:0] A, B;
  logic Cin, valid;
  logic [1:0] phase;
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic cin;
    logic [1:0] ph;
  } snap_t;
  snap_t exp_q[$];
  snap_t m = '0;
  int n_cmp = 0, n_bad = 0, v_cnt = 0, m_v = 0;
  sw_operand_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .SW(SW),
    .key_n(key_n),
    .A(A),
    .B(B),
    .Cin(Cin),
    .valid(valid),
    .phase(phase)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (valid === 1'b1) v_cnt <= v_cnt + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic model(input logic [9:0] sw);
    if (sw[9]) m = '0;
    else case (m.ph)
      2'd0: begin m.a = sw[3:0]; m.ph = 2'd1; end
      2'd1: begin m.b = sw[3:0]; m.cin = sw[8]; m.ph = 2'd2; m_v++; end
      default: m.ph = 2'd0;
    endcase
    exp_q.push_back(m);
  endtask
  task automatic compare(input string tag);
    snap_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_A"}, A, e.a);
    check({tag, "_B"}, B, e.b);
    check({tag, "_Cin"}, Cin, e.cin);
    check({tag, "_phase"}, phase, e.ph);
    check({tag, "_valid_cycles"}, v_cnt, m_v);
    tick(1);
  endtask
  task automatic press(input string tag, input logic [9:0] sw, input int low);
    SW = sw;
    key_n = 1'b0;
    tick(low);
    key_n = 1'b1;
    tick(8);
    model(sw);
    compare(tag);
  endtask
  initial begin
    SW = 10'($urandom);
    key_n = 1'($urandom);
    reset = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_Cin", Cin, 0);
    check("rst_valid", valid, 0);
    check("rst_phase", phase, 0);
    tick(1);
    reset = 1'b0;
    SW = '0;
    key_n = 1'b1;
    tick(3);
    SW = 10'h009;
    key_n = 1'b0;
    tick(5);
    check("timing_early_phase", phase, 0);
    tick(1);
    check("timing_A", A, 4'h9);
    check("timing_phase", phase, 1);
    key_n = 1'b1;
    tick(8);
    model(10'h009);
    compare("clean_a");
    press("clean_b", 10'h107, 6);
    press("wrap1", 10'h000, 6);
    press("set_a3", 10'h003, 6);
    press("set_b4", 10'h004, 6);
    press("wrap2", 10'h00c, 6);
    press("wrap_f", 10'h00f, 6);
    press("b2", 10'h102, 6);
    press("wrap3", 10'h000, 6);
    SW = 10'h001;
    for (int i = 0; i < 4; i++) begin
      key_n = i[0];
      tick(1);
    end
    key_n = 1'b0;
    tick(5);
    check("bounce_early_phase", phase, 0);
    tick(3);
    key_n = 1'b1;
    tick(8);
    model(10'h001);
    compare("bounce");
    press("b_after_bounce", 10'h10a, 6);
    press("wrap4", 10'h000, 6);
    press("held", 10'h005, 40);
    press("abort", 10'h203, 6);
    press("after_abort", 10'h006, 6);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
